// File: rtl/alu_8bit_pkg.sv
// alu_8bit_pkg
// Shared opcode definitions for the registered 8-bit ALU.
//   alu_op_t : 4-bit operation select type
//   OP_*     : opcode encodings carried on ALU_Sel
package alu_8bit_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t OP_ADD  = 4'b0000;
    localparam alu_op_t OP_SUB  = 4'b0001;
    localparam alu_op_t OP_AND  = 4'b0010;
    localparam alu_op_t OP_OR   = 4'b0011;
    localparam alu_op_t OP_XOR  = 4'b0100;
    localparam alu_op_t OP_NOT  = 4'b0101;
    localparam alu_op_t OP_SHL  = 4'b0110;
    localparam alu_op_t OP_SHR  = 4'b0111;
    localparam alu_op_t OP_LT   = 4'b1000;
    localparam alu_op_t OP_EQ   = 4'b1001;
    localparam alu_op_t OP_NAND = 4'b1010;
    localparam alu_op_t OP_NOR  = 4'b1011;
    localparam alu_op_t OP_XNOR = 4'b1100;
    localparam alu_op_t OP_ROL  = 4'b1101;
    localparam alu_op_t OP_ROR  = 4'b1110;
    localparam alu_op_t OP_GT   = 4'b1111;

endpackage

// File: rtl/alu_8bit_comb.sv
// alu_8bit_comb
// Purely combinational function unit of the ALU.
//   a, b       : unsigned 8-bit operands
//   sel        : operation select (alu_op_t)
//   next_out   : result to be registered
//   next_carry : carry / borrow / shifted-out bit to be registered
module alu_8bit_comb
    import alu_8bit_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  alu_op_t    sel,
    output logic [7:0] next_out,
    output logic       next_carry
);

    logic [8:0] sum;
    logic [8:0] diff;

    // 9-bit forms so bit 8 is the carry (ADD) or the borrow (SUB, set when a < b).
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        next_out   = 8'h00;
        next_carry = 1'b0;
        case (sel)
            OP_ADD: begin
                next_out   = sum[7:0];
                next_carry = sum[8];
            end
            OP_SUB: begin
                next_out   = diff[7:0];
                next_carry = diff[8];
            end
            OP_AND:  next_out = a & b;
            OP_OR:   next_out = a | b;
            OP_XOR:  next_out = a ^ b;
            OP_NOT:  next_out = ~a;
            OP_SHL: begin
                next_out   = {a[6:0], 1'b0};
                next_carry = a[7];
            end
            OP_SHR: begin
                next_out   = {1'b0, a[7:1]};
                next_carry = a[0];
            end
            OP_LT:   next_out = {7'b0, (a < b)};
            OP_EQ:   next_out = {7'b0, (a == b)};
            OP_NAND: next_out = ~(a & b);
            OP_NOR:  next_out = ~(a | b);
            OP_XNOR: next_out = ~(a ^ b);
            OP_ROL: begin
                next_out   = {a[6:0], a[7]};
                next_carry = a[7];
            end
            OP_ROR: begin
                next_out   = {a[0], a[7:1]};
                next_carry = a[0];
            end
            OP_GT:   next_out = {7'b0, (a > b)};
            default: begin
                next_out   = 8'h00;
                next_carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_8bit.sv
// alu_8bit
// Registered 8-bit ALU: one operation per cycle, result one cycle after capture.
//   clk      : clock, rising-edge active
//   rst      : asynchronous active-high reset, clears outputs immediately
//   A, B     : unsigned 8-bit operands
//   ALU_Sel  : 4-bit operation select
//   ALU_Out  : registered 8-bit result
//   CarryOut : registered carry / borrow / shifted-out bit
module alu_8bit
    import alu_8bit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [3:0] ALU_Sel,
    output logic [7:0] ALU_Out,
    output logic       CarryOut
);

    logic [7:0] next_out;
    logic       next_carry;

    alu_8bit_comb u_comb (
        .a          (A),
        .b          (B),
        .sel        (alu_op_t'(ALU_Sel)),
        .next_out   (next_out),
        .next_carry (next_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALU_Out  <= 8'h00;
            CarryOut <= 1'b0;
        end else begin
            ALU_Out  <= next_out;
            CarryOut <= next_carry;
        end
    end

endmodule

// File: tb/tb_alu_8bit.sv
// tb_alu_8bit
// Self-checking bench for alu_8bit. Expected {CarryOut, ALU_Out} values are
// pushed to a scoreboard queue as each op is driven and popped after the
// capturing clock edge.
module tb_alu_8bit;

    logic       clk;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] ALU_Sel;
    logic [7:0] ALU_Out;
    logic       CarryOut;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] sb[$];

    alu_8bit dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .ALU_Sel  (ALU_Sel),
        .ALU_Out  (ALU_Out),
        .CarryOut (CarryOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model, written from the operation table, used for random ops.
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] s);
        int ia;
        int ib;
        int r;
        logic c;
        ia = int'(a);
        ib = int'(b);
        c  = 1'b0;
        r  = 0;
        case (s)
            4'd0:  begin r = ia + ib; c = (r > 255); end
            4'd1:  begin r = ia - ib; c = (ia < ib); if (r < 0) r = r + 256; end
            4'd2:  r = ia & ib;
            4'd3:  r = ia | ib;
            4'd4:  r = ia ^ ib;
            4'd5:  r = 255 - ia;
            4'd6:  begin r = ia * 2; c = (ia >= 128); end
            4'd7:  begin r = ia / 2; c = (ia % 2 == 1); end
            4'd8:  r = (ia < ib) ? 1 : 0;
            4'd9:  r = (ia == ib) ? 1 : 0;
            4'd10: r = 255 - (ia & ib);
            4'd11: r = 255 - (ia | ib);
            4'd12: r = 255 - (ia ^ ib);
            4'd13: begin r = (ia * 2) + (ia / 128); c = (ia >= 128); end
            4'd14: begin r = (ia / 2) + ((ia % 2) * 128); c = (ia % 2 == 1); end
            default: r = (ia > ib) ? 1 : 0;
        endcase
        model = {c, 8'(r % 256)};
    endfunction

    // Drive one op on the falling edge and record what it must produce.
    task automatic drive_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                            input logic [7:0] exp_out, input logic exp_c);
        @(negedge clk);
        A       = a;
        B       = b;
        ALU_Sel = s;
        sb.push_back({exp_c, exp_out});
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        A       = 8'hFF;
        B       = 8'h01;
        ALU_Sel = 4'd0;
        #1;
        n_cmp++;
        if ({CarryOut, ALU_Out} !== 9'h000) begin
            n_err++;
            $display("FAIL reset_initial: got %h required 000", {CarryOut, ALU_Out});
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({CarryOut, ALU_Out} !== 9'h000) begin
                n_err++;
                $display("FAIL reset_hold_%0d: got %h required 000", i, {CarryOut, ALU_Out});
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_midcycle();
        logic [8:0] exp;
        drive_op(8'h80, 8'h81, 4'd0, 8'h01, 1'b1);
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        n_cmp++;
        if ({CarryOut, ALU_Out} !== exp) begin
            n_err++;
            $display("FAIL pre_reset_add: got %h required %h", {CarryOut, ALU_Out}, exp);
        end
        // New op pending, then reset lands before the edge that would capture it.
        A       = 8'h0F;
        B       = 8'h01;
        ALU_Sel = 4'd5;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({CarryOut, ALU_Out} !== 9'h000) begin
            n_err++;
            $display("FAIL reset_async: got %h required 000", {CarryOut, ALU_Out});
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({CarryOut, ALU_Out} !== 9'h000) begin
                n_err++;
                $display("FAIL reset_mid_hold_%0d: got %h required 000", i,
                         {CarryOut, ALU_Out});
            end
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_ops();
        logic [7:0] exp_out[10] = '{8'h0C, 8'h08, 8'h02, 8'h0A, 8'h08,
                                    8'hF5, 8'h14, 8'h05, 8'h00, 8'h00};
        logic [8:0] exp;
        for (int i = 0; i < 10; i++) begin
            drive_op(8'h0A, 8'h02, 4'(i), exp_out[i], 1'b0);
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            n_cmp++;
            if ({CarryOut, ALU_Out} !== exp) begin
                n_err++;
                $display("FAIL basic_op%0d: got %h required %h", i, {CarryOut, ALU_Out}, exp);
            end
        end
    endtask

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] s;
        logic [7:0] o;
        logic       c;
    } vec_t;

    task automatic test_carry_and_ext();
        vec_t v[16] = '{
            '{8'hFF, 8'h01, 4'd0,  8'h00, 1'b1},
            '{8'h02, 8'h0A, 4'd1,  8'hF8, 1'b1},
            '{8'h81, 8'h00, 4'd6,  8'h02, 1'b1},
            '{8'h81, 8'h00, 4'd7,  8'h40, 1'b1},
            '{8'h5A, 8'h5A, 4'd9,  8'h01, 1'b0},
            '{8'h5A, 8'h5A, 4'd8,  8'h00, 1'b0},
            '{8'h5A, 8'h5A, 4'd15, 8'h00, 1'b0},
            '{8'h03, 8'h07, 4'd8,  8'h01, 1'b0},
            '{8'h07, 8'h03, 4'd15, 8'h01, 1'b0},
            '{8'hF0, 8'h3C, 4'd10, 8'hCF, 1'b0},
            '{8'hF0, 8'h3C, 4'd11, 8'h03, 1'b0},
            '{8'hF0, 8'h3C, 4'd12, 8'h33, 1'b0},
            '{8'h81, 8'h00, 4'd13, 8'h03, 1'b1},
            '{8'h81, 8'h00, 4'd14, 8'hC0, 1'b1},
            '{8'h0A, 8'h0A, 4'd1,  8'h00, 1'b0},
            '{8'h80, 8'h80, 4'd0,  8'h00, 1'b1}
        };
        logic [8:0] exp;
        for (int i = 0; i < 16; i++) begin
            drive_op(v[i].a, v[i].b, v[i].s, v[i].o, v[i].c);
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            n_cmp++;
            if ({CarryOut, ALU_Out} !== exp) begin
                n_err++;
                $display("FAIL ext_vec%0d sel=%0d a=%h b=%h: got %h required %h", i, v[i].s,
                         v[i].a, v[i].b, {CarryOut, ALU_Out}, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] s;
        logic [8:0] e;
        logic [8:0] exp;
        for (int i = 0; i < 64; i++) begin
            a = 8'($urandom_range(0, 255));
            b = (i % 8 == 0) ? a : 8'($urandom_range(0, 255));
            s = 4'(i % 16);
            e = model(a, b, s);
            drive_op(a, b, s, e[7:0], e[8]);
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            n_cmp++;
            if ({CarryOut, ALU_Out} !== exp) begin
                n_err++;
                $display("FAIL b2b_%0d sel=%0d a=%h b=%h: got %h required %h", i, s, a, b,
                         {CarryOut, ALU_Out}, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [8:0] exp;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            A       = 8'hFF;
            B       = 8'hFF;
            ALU_Sel = 4'd0;
            #2;
            A       = 8'h10 + 8'(i);
            B       = 8'h01;
            ALU_Sel = 4'd4;
            sb.push_back({1'b0, (8'h10 + 8'(i)) ^ 8'h01});
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            n_cmp++;
            if ({CarryOut, ALU_Out} !== exp) begin
                n_err++;
                $display("FAIL glitch_pre_%0d: got %h required %h", i, {CarryOut, ALU_Out}, exp);
            end
            // Input wiggle after the edge must not disturb the held result.
            A       = 8'hAA;
            B       = 8'h55;
            ALU_Sel = 4'd5;
            #2;
            n_cmp++;
            if ({CarryOut, ALU_Out} !== exp) begin
                n_err++;
                $display("FAIL glitch_hold_%0d: got %h required %h", i,
                         {CarryOut, ALU_Out}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_ops();
        test_reset_midcycle();
        test_carry_and_ext();
        test_back_to_back();
        test_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
